// File: rtl/uart_rx_if.sv
// Serial-side bundle of the UART receiver: rx line in, byte/status strobes out.
// With UART_RX_PARITY_EN defined the bundle also carries parity_err.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (input rx, output data, output valid, output framing_err,
                    output busy, output parity_err);
    modport slave  (output rx, input data, input valid, input framing_err,
                    input busy, input parity_err);
`else
    modport master (input rx, output data, output valid, output framing_err,
                    output busy);
    modport slave  (output rx, input data, input valid, input framing_err,
                    input busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), LSB first.
// Bytes are delivered as a one-cycle valid pulse; bad stop bits give framing_err.
//
//  state  | meaning
//  IDLE   | line idle, waiting for rx_s falling edge
//  START  | start bit: majority at s=9 confirms it, then waits for end of bit
//  DATA   | 8 data bits, shifted in at end of each bit
//  PARITY | even-parity bit (UART_RX_PARITY_EN only)
//  STOP   | stop bit evaluated at mid-bit (s=9), then back to IDLE
//  BREAK  | stop bit was low; wait for the line to return high
module uart_rx #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.master bus
);
    localparam int          TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]  s_q, s_d;
    logic [1:0]  samp_q, samp_d;
    logic        bit_q, bit_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        tick, maj;
`ifdef UART_RX_PARITY_EN
    logic        perr_q, perr_d;
    logic        par_bad_q, par_bad_d;
`endif

    assign tick = (tick_cnt_q == TICK_MAX);
    // samp_q[1] taken at s=7, samp_q[0] at s=8, live rx_s_q completes the vote at s=9
    assign maj  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        s_d        = tick ? s_q + 4'd1 : s_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d     = 1'b0;
        par_bad_d  = par_bad_q;
`endif
        if (tick && s_q == 4'd7) samp_d[1] = rx_s_q;
        if (tick && s_q == 4'd8) samp_d[0] = rx_s_q;
        if (tick && s_q == 4'd9) bit_d = maj;

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = START;
                    s_d        = 4'd0;
                    tick_cnt_d = 16'd0;
                end
            end
            START: begin
                if (tick && s_q == 4'd9 && maj) begin
                    state_d = IDLE;
                end else if (tick && s_q == 4'd15) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (tick && s_q == 4'd15) begin
                    shift_d   = {bit_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && s_q == 4'd15) begin
                    par_bad_d = bit_q ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && s_q == 4'd9) begin
                    if (maj) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (tick && rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= 16'd0;
            s_q        <= 4'd0;
            samp_q     <= 2'b11;
            bit_q      <= 1'b1;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= bus.rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            tick_cnt_q <= tick_cnt_d;
            s_q        <= s_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    assign bus.data        = data_q;
    assign bus.valid       = valid_q;
    assign bus.framing_err = ferr_q;
    assign bus.busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at TICK_DIV=10 (160 clk per bit, 10 time units per clk).
module tb_uart_rx;
    localparam int BIT = 160;

    logic clk = 1'b0;
    logic reset;
    uart_rx_if bus ();

    uart_rx #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int perr_cnt  = 0;
    int bad_pulse = 0;
    int pulse_prev = 0;
    logic [7:0] data_log [$];
    time frame_t0, t_valid;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always @(negedge clk) begin
        int p;
        p = 0;
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            data_log.push_back(bus.data);
            t_valid = $time;
            p++;
        end
        if (bus.framing_err === 1'b1) begin ferr_cnt++; p++; end
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err === 1'b1) begin perr_cnt++; p++; end
`endif
        if (p > 1 || (p > 0 && pulse_prev > 0)) bad_pulse++;
        pulse_prev = p;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int bclk, input logic stop_v);
        @(negedge clk);
        bus.rx = 1'b0;
        frame_t0 = $time;
        #(bclk * 10);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bclk * 10);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = (^b) ^ par_flip;
        #(bclk * 10);
`endif
        bus.rx = stop_v;
        #(bclk * 10);
    endtask

    initial begin
        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  32'(bus.data), 32'h00);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_ferr",  32'(bus.framing_err), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        reset = 1'b0;
        #(20 * 10);

        // 1: reset during bit 3 of 0xFF
        @(negedge clk);
        bus.rx = 1'b0;
        #(BIT * 10);
        bus.rx = 1'b1;
        #(3 * BIT * 10 + 80 * 10);
        chk("t1_busy_pre", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("t1_rst_busy",  32'(bus.busy), 32'h0);
        chk("t1_rst_data",  32'(bus.data), 32'h00);
        chk("t1_rst_valid", 32'(bus.valid), 32'h0);
        #19;
        reset = 1'b0;
        #(2 * BIT * 10);
        chk("t1_no_valid", 32'(valid_cnt), 32'd0);
        chk("t1_no_ferr",  32'(ferr_cnt), 32'd0);
        send(8'h3C, BIT, 1'b1);
        #(BIT * 10);
        chk("t1_cnt",  32'(valid_cnt), 32'd1);
        chk("t1_data", 32'(bus.data), 32'h3C);

        // 2: single frame 0xA5
        fork
            send(8'hA5, BIT, 1'b1);
            begin
                #(5 * BIT * 10);
                chk("t2_busy_mid", 32'(bus.busy), 32'h1);
            end
        join
        chk("t2_busy_end", 32'(bus.busy), 32'h0);
        chk("t2_cnt",  32'(valid_cnt), 32'd2);
        chk("t2_data", 32'(bus.data), 32'hA5);
        chk("t2_ferr", 32'(ferr_cnt), 32'd0);
        chk("t2_latency", 32'((t_valid - frame_t0) / 10 >= 1520 && (t_valid - frame_t0) / 10 <= 1560), 32'h1);
        #(BIT * 10);

        // 3: back-to-back frames
        send(8'h00, BIT, 1'b1);
        send(8'hFF, BIT, 1'b1);
        send(8'h55, BIT, 1'b1);
        #(BIT * 10);
        chk("t3_cnt", 32'(valid_cnt), 32'd5);
        chk("t3_d0", 32'(data_log[2]), 32'h00);
        chk("t3_d1", 32'(data_log[3]), 32'hFF);
        chk("t3_d2", 32'(data_log[4]), 32'h55);

        // 4: 40-clk low glitch
        @(negedge clk);
        bus.rx = 1'b0;
        #(20 * 10);
        chk("t4_busy_mid", 32'(bus.busy), 32'h1);
        #(20 * 10);
        bus.rx = 1'b1;
        #(BIT * 10);
        chk("t4_busy_end", 32'(bus.busy), 32'h0);
        chk("t4_cnt",  32'(valid_cnt), 32'd5);
        chk("t4_ferr", 32'(ferr_cnt), 32'd0);

        // 5: bad stop bit then line held low
        send(8'h81, BIT, 1'b0);
        #(BIT * 10);
        chk("t5_busy_break", 32'(bus.busy), 32'h1);
        #(2 * BIT * 10);
        bus.rx = 1'b1;
        #(2 * BIT * 10);
        chk("t5_ferr", 32'(ferr_cnt), 32'd1);
        chk("t5_cnt",  32'(valid_cnt), 32'd5);
        chk("t5_data", 32'(bus.data), 32'h55);
        chk("t5_busy", 32'(bus.busy), 32'h0);
        send(8'hC3, BIT, 1'b1);
        #(BIT * 10);
        chk("t5_next_cnt",  32'(valid_cnt), 32'd6);
        chk("t5_next_data", 32'(bus.data), 32'hC3);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send(8'h5A, BIT, 1'b1);
        par_flip = 1'b0;
        #(BIT * 10);
        chk("par_perr", 32'(perr_cnt), 32'd1);
        chk("par_cnt",  32'(valid_cnt), 32'd6);
        chk("par_data", 32'(bus.data), 32'hC3);
`endif

        // 6: +/-3% bit-period skew
        send(8'h5A, 165, 1'b1);
        #(BIT * 10);
        chk("t6_slow_cnt",  32'(valid_cnt), 32'd7);
        chk("t6_slow_data", 32'(bus.data), 32'h5A);
        send(8'h5A, 155, 1'b1);
        #(BIT * 10);
        chk("t6_fast_cnt",  32'(valid_cnt), 32'd8);
        chk("t6_fast_data", 32'(bus.data), 32'h5A);
        chk("t6_ferr",      32'(ferr_cnt), 32'd1);

        chk("pulse_excl", 32'(bad_pulse), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
